// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the RAM-port arbiter.
//   oplen_t      2-bit access size minus one (bytes)
//   arb_state_t  arbiter FSM states
//   owner_t      which requester owns the outstanding RAM transaction
//   GPIO_ADDR    byte address of the GPIO register; the arbiter passes it through unchanged
package mem_pkg;

  typedef logic [1:0] oplen_t;

  localparam oplen_t OPLEN_B = 2'b00;
  localparam oplen_t OPLEN_H = 2'b01;
  localparam oplen_t OPLEN_W = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [31:0] GPIO_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way requester picker.
//   req_a, req_b  pending requests (a = fetch side, b = data side in the arbiter)
//   last          previous grant (0 = a, 1 = b)
//   mode          0 = alternate on a tie, 1 = b always wins a tie
//   grant         chosen requester (0 = a, 1 = b); only meaningful when a request is pending
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  input  logic mode,
  output logic grant
);

  // Pick a single requester; on a tie, b wins in fixed mode, otherwise the side not served last.
  always_comb begin
    grant = 1'b0;
    if (req_a && req_b) begin
      grant = mode | ~last;
    end else if (req_b) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the RAM's single command port between the fetch
// and load/store stages, one outstanding transaction at a time.
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_done)
//   if_done/if_rdata               fetch completion pulse and fetched word
//   d_req/d_addr/d_oplen/d_we/d_wdata  data request (held until d_done)
//   d_done/d_rdata                 data completion pulse and load result
//   err                            pulses with done when the RAM failed to answer in time
//   mem_enable/mem_addr/mem_oplen/mem_we/mem_data  RAM command (enable is a one-cycle strobe)
//   mem_valid/mem_result           RAM response
// All outputs are registered.
module mem_port_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_oplen,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_oplen,
  output logic        mem_we,
  output logic [31:0] mem_data,
  input  logic        mem_valid,
  input  logic [31:0] mem_result
);
  import mem_pkg::*;

  // The counter is cleared on grant, so this value is seen on the TIMEOUT-th WAIT edge.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic       PRIO_DATA    = (PRIO_MODE != 0);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        if_done_q, if_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_done_q, d_done_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic        mem_enable_q, mem_enable_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  oplen_t      mem_oplen_q, mem_oplen_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic        any_req_s;
  logic        grant_s;
  owner_t      grant_own_s;
  logic        timeout_s;

  assign any_req_s   = if_req | d_req;
  assign grant_own_s = owner_t'(grant_s);
  assign timeout_s   = (cnt_q == TIMEOUT_LAST);

  rr_pick2 u_pick (
    .req_a (if_req),
    .req_b (d_req),
    .last  (last_q),
    .mode  (PRIO_DATA),
    .grant (grant_s)
  );

  // State and output registers; reset drops any outstanding access without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_q       <= OWN_IF;
      cnt_q        <= 8'd0;
      if_done_q    <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= 32'd0;
      err_q        <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_oplen_q  <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      if_done_q    <= if_done_d;
      if_rdata_q   <= if_rdata_d;
      d_done_q     <= d_done_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
      mem_oplen_q  <= mem_oplen_d;
      mem_we_q     <= mem_we_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Next state: grant from IDLE, leave WAIT on a response or on timeout.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = WAIT;
          owner_d = grant_own_s;
          last_d  = grant_own_s;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_valid || timeout_s) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values: command capture on grant, result/abort routing to the owner.
  always_comb begin
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
    mem_enable_d = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_oplen_d  = mem_oplen_q;
    mem_we_d     = mem_we_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          mem_enable_d = 1'b1;
          if (grant_own_s == OWN_D) begin
            mem_addr_d  = d_addr;
            mem_oplen_d = d_oplen;
            mem_we_d    = d_we;
            mem_data_d  = d_wdata;
          end else begin
            mem_addr_d  = if_addr;
            mem_oplen_d = OPLEN_W;
            mem_we_d    = 1'b0;
            mem_data_d  = 32'd0;
          end
        end else begin
          mem_enable_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          if (owner_q == OWN_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_result;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_result;
          end
        end else if (timeout_s) begin
          err_d = 1'b1;
          if (owner_q == OWN_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = 32'd0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = 32'd0;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      default: begin
        mem_enable_d = 1'b0;
      end
    endcase
  end

  assign if_done    = if_done_q;
  assign if_rdata   = if_rdata_q;
  assign d_done     = d_done_q;
  assign d_rdata    = d_rdata_q;
  assign err        = err_q;
  assign mem_enable = mem_enable_q;
  assign mem_addr   = mem_addr_q;
  assign mem_oplen  = mem_oplen_q;
  assign mem_we     = mem_we_q;
  assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [1:0]  d_oplen;
  logic        if_done, d_done, err, mem_enable, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_data;
  logic [1:0]  mem_oplen;
  logic        mem_valid;
  logic [31:0] mem_result;

  // second instance in fixed data-first mode with a trivial one-cycle responder
  logic        p_if_done, p_d_done, p_err, p_enable, p_we;
  logic [31:0] p_if_rdata, p_d_rdata, p_addr, p_data;
  logic [1:0]  p_oplen;
  logic        p_valid = 1'b0;
  logic [31:0] p_result = 32'h5A5A_0000;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_oplen(d_oplen), .d_we(d_we), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_oplen(mem_oplen),
    .mem_we(mem_we), .mem_data(mem_data), .mem_valid(mem_valid), .mem_result(mem_result)
  );

  mem_port_arbiter #(.PRIO_MODE(1), .TIMEOUT(15)) dut_p (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(p_if_done), .if_rdata(p_if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_oplen(d_oplen), .d_we(d_we), .d_wdata(d_wdata),
    .d_done(p_d_done), .d_rdata(p_d_rdata), .err(p_err),
    .mem_enable(p_enable), .mem_addr(p_addr), .mem_oplen(p_oplen),
    .mem_we(p_we), .mem_data(p_data), .mem_valid(p_valid), .mem_result(p_result)
  );

  always @(posedge clk) p_valid <= p_enable;

  // ---------------- RAM model (byte array + GPIO register) ----------------
  logic [7:0]  ram [0:255];
  logic [31:0] gpio;
  logic        ram_init_done = 1'b0;
  logic        ram_valid = 1'b0;
  logic [31:0] ram_result = 32'h0;
  logic        ram_mute;
  logic        stray_v;

  assign mem_valid  = ram_valid | stray_v;
  assign mem_result = ram_result;

  function automatic logic [31:0] len_mask(input logic [1:0] ol);
    case (ol)
      2'b00:   len_mask = 32'h0000_00FF;
      2'b01:   len_mask = 32'h0000_FFFF;
      2'b10:   len_mask = 32'h00FF_FFFF;
      default: len_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] ram_rd(input logic [7:0] a, input logic [1:0] ol);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++)
      if (i <= int'(ol)) r[8*i +: 8] = ram[8'(a + 8'(i))];
    return r;
  endfunction

  always @(posedge clk) begin
    ram_valid <= 1'b0;
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[0] <= 8'h93; ram[1] <= 8'h00; ram[2] <= 8'h10; ram[3] <= 8'h00;
      gpio <= 32'h0;
      ram_init_done <= 1'b1;
    end else if (mem_enable && !ram_mute) begin
      ram_valid <= 1'b1;
      if (mem_addr == GPIO_ADDR) begin
        if (mem_we) begin
          gpio       <= mem_data & len_mask(mem_oplen);
          ram_result <= 32'h0;
        end else begin
          ram_result <= gpio & len_mask(mem_oplen);
        end
      end else if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (i <= int'(mem_oplen)) ram[8'(mem_addr[7:0] + 8'(i))] <= mem_data[8*i +: 8];
        ram_result <= 32'h0;
      end else begin
        ram_result <= ram_rd(mem_addr[7:0], mem_oplen);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  oplen;
    logic        we;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    int          lat;   // cycles from mem_enable to done
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  function automatic void push_cmd(input logic [31:0] a, input logic [1:0] ol,
                                   input logic we, input logic [31:0] wd);
    cmd_t c;
    c.addr = a; c.oplen = ol; c.we = we; c.data = wd;
    cmd_q.push_back(c);
  endfunction

  function automatic void push_rsp(input logic is_d, input logic [31:0] rd,
                                   input logic e, input int lat);
    rsp_t r;
    r.is_d = is_d; r.rdata = rd; r.err = e; r.lat = lat;
    rsp_q.push_back(r);
  endfunction

  // monitor: compares every command strobe and every done pulse against the queues
  initial begin : monitor
    cmd_t c;
    rsp_t r;
    int cyc, en_cyc;
    logic [31:0] hold_if, hold_d, got_rd, got_hold, exp_hold;
    cyc = 0; en_cyc = 0; hold_if = 32'h0; hold_d = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hold_if = 32'h0;
        hold_d  = 32'h0;
      end else begin
        if (mem_enable) begin
          en_cyc = cyc;
          checks++;
          if (cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected got addr=%h len=%b we=%b data=%h", mem_addr, mem_oplen, mem_we, mem_data);
          end else begin
            c = cmd_q.pop_front();
            if (mem_addr !== c.addr || mem_oplen !== c.oplen || mem_we !== c.we || mem_data !== c.data) begin
              errors++;
              $display("FAIL cmd got addr=%h len=%b we=%b data=%h expected addr=%h len=%b we=%b data=%h",
                       mem_addr, mem_oplen, mem_we, mem_data, c.addr, c.oplen, c.we, c.data);
            end
          end
        end
        if (if_done || d_done) begin
          checks++;
          if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected got if_done=%b d_done=%b err=%b", if_done, d_done, err);
          end else begin
            r        = rsp_q.pop_front();
            got_rd   = d_done ? d_rdata : if_rdata;
            got_hold = d_done ? if_rdata : d_rdata;
            exp_hold = r.is_d ? hold_if : hold_d;
            if ((if_done && d_done) || d_done !== r.is_d || got_rd !== r.rdata ||
                err !== r.err || (cyc - en_cyc) != r.lat || got_hold !== exp_hold) begin
              errors++;
              $display("FAIL rsp got d=%b rdata=%h err=%b lat=%0d other=%h expected d=%b rdata=%h err=%b lat=%0d other=%h",
                       d_done, got_rd, err, cyc - en_cyc, got_hold, r.is_d, r.rdata, r.err, r.lat, exp_hold);
            end
            if (r.is_d) hold_d = r.rdata;
            else        hold_if = r.rdata;
          end
        end else if (err) begin
          checks++;
          errors++;
          $display("FAIL err_without_done got err=1 expected 0");
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (if_done || d_done) break;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL done_timeout got no done after %0d cycles expected done", n);
        break;
      end
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, output int n);
    push_cmd(a, OPLEN_W, 1'b0, 32'h0);
    push_rsp(1'b0, exp, 1'b0, 2);
    if_addr = a;
    if_req  = 1'b1;
    wait_done(40, n);
    if_req  = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input logic [1:0] ol, input logic we,
                         input logic [31:0] wd, input logic [31:0] exp,
                         input logic e, input int lat);
    int n;
    push_cmd(a, ol, we, wd);
    push_rsp(1'b1, exp, e, lat);
    d_addr = a; d_oplen = ol; d_we = we; d_wdata = wd;
    d_req  = 1'b1;
    wait_done(40, n);
    d_req  = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (if_done || d_done) n++;
    end
  endtask

  function automatic logic outs_nonzero();
    return (|{if_done, if_rdata, d_done, d_rdata, err, mem_enable, mem_addr, mem_oplen, mem_we, mem_data,
              p_if_done, p_if_rdata, p_d_done, p_d_rdata, p_err, p_enable, p_addr, p_oplen, p_we, p_data}) !== 1'b0;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, n_done, p_if_cnt, p_d_cnt;
    rst = 1'b1; ram_mute = 1'b0; stray_v = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_oplen = 2'b00; d_we = 1'b0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);

    checks++;
    if (outs_nonzero()) begin
      errors++;
      $display("FAIL reset_state got nonzero outputs expected all 0");
    end
    rst = 1'b0;
    @(negedge clk);

    // fetch after reset
    do_fetch(32'h0, 32'h0010_0093, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL fetch_latency got %0d expected 3", n);
    end

    // store byte then load it back
    do_data(32'h40, OPLEN_B, 1'b1, 32'h0000_00AB, 32'h0, 1'b0, 2);
    do_data(32'h40, OPLEN_B, 1'b0, 32'h0, 32'h0000_00AB, 1'b0, 2);

    // GPIO write and read back
    do_data(GPIO_ADDR, OPLEN_W, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 2);
    do_data(GPIO_ADDR, OPLEN_W, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 2);

    // half-word store keeps only the low 16 bits
    do_data(32'h50, OPLEN_H, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    do_data(32'h50, OPLEN_W, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0, 2);

    // timeout, then a stray mem_valid in IDLE
    ram_mute = 1'b1;
    do_data(32'h44, OPLEN_W, 1'b0, 32'h0, 32'h0, 1'b1, 15);
    ram_mute = 1'b0;
    repeat (2) @(negedge clk);
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    count_dones(5, n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL stray_valid got %0d dones expected 0", n);
    end

    // reset while waiting for the RAM
    ram_mute = 1'b1;
    push_cmd(32'h100, OPLEN_W, 1'b0, 32'h0);
    if_addr = 32'h100;
    if_req  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outs_nonzero()) begin
      errors++;
      $display("FAIL reset_in_wait got nonzero outputs expected all 0");
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ram_mute = 1'b0;
    count_dones(4, n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d dones expected 0", n);
    end
    do_fetch(32'h0, 32'h0010_0093, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL fetch_after_reset_latency got %0d expected 3", n);
    end
    repeat (3) @(negedge clk);

    // contention: both requesters held high for 8 grants
    for (int k = 0; k < 4; k++) begin
      push_cmd(32'h40, OPLEN_B, 1'b0, 32'h0);
      push_rsp(1'b1, 32'h0000_00AB, 1'b0, 2);
      push_cmd(32'h0, OPLEN_W, 1'b0, 32'h0);
      push_rsp(1'b0, 32'h0010_0093, 1'b0, 2);
    end
    if_addr = 32'h0;
    d_addr = 32'h40; d_oplen = OPLEN_B; d_we = 1'b0; d_wdata = 32'h0;
    if_req = 1'b1; d_req = 1'b1;
    n_done = 0; p_if_cnt = 0; p_d_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (p_if_done) p_if_cnt++;
      if (p_d_done)  p_d_cnt++;
      if (if_done || d_done) n_done++;
      if (n_done == 8) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n_done != 8) begin
      errors++;
      $display("FAIL contention_grants got %0d expected 8", n_done);
    end
    checks++;
    if (p_if_cnt != 0 || p_d_cnt != 8) begin
      errors++;
      $display("FAIL prio_data_only got if=%0d d=%0d expected if=0 d=8", p_if_cnt, p_d_cnt);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_leftover got cmd=%0d rsp=%0d expected 0 0", cmd_q.size(), rsp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the internal RAM. Multiplexes two requesters onto the RAM's single enable/valid port: the instruction-fetch stage and the load/store stage.
- Allows one outstanding RAM transaction at a time. Selects the requester by round-robin or by fixed data-first priority.
- Returns the RAM result to the requester that owns the transaction. Flags an error if the RAM does not respond within a bounded time.

Parameters:
- PRIO_MODE, 0: 0 = round-robin when both requesters are pending; 1 = data port always wins.
- TIMEOUT, 15: cycles to wait in WAIT for mem_valid before aborting with err; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held with the other d_* inputs until d_done
- d_addr  in  32  data byte address; 32'hFFFFFFFF is the GPIO register
- d_oplen  in  2  access size minus 1, in bytes (00 = 1 byte .. 11 = 4 bytes)
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  32  store data, little-endian, low bytes used
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load result, zero-extended as returned by the RAM
- err  out  1  one-cycle pulse, coincident with the done pulse of an aborted transaction
- mem_enable  out  1  one-cycle pulse: RAM command strobe
- mem_addr  out  32  RAM address
- mem_oplen  out  2  RAM access size
- mem_we  out  1  RAM write enable
- mem_data  out  32  RAM write data
- mem_valid  in  1  RAM response strobe
- mem_result  in  32  RAM read data

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = fetch (so the data port wins the first tie); timeout counter 0. Reset is asynchronous.
- All outputs are registered.
- States are IDLE, WAIT.
- IDLE with no request: hold state; mem_enable = 0.
- IDLE with any request, at a clock edge:
  - Pick the owner:
    - only one pending: that one;
    - both pending, PRIO_MODE=1: data;
    - both pending, PRIO_MODE=0: the requester opposite last_grant.
  - Latch the mem_* command from the owner. A fetch is always mem_oplen = 11, mem_we = 0, mem_data = 0.
  - Pulse mem_enable for exactly one cycle, update last_grant, clear the counter, go to WAIT.
- WAIT:
  - mem_enable = 0; mem_addr, mem_oplen, mem_we and mem_data hold stable.
  - Counter increments each cycle.
- mem_valid = 1 in WAIT:
  - Register mem_result into the owner's rdata.
  - Pulse the owner's done for one cycle; go to IDLE.
  - The non-owner's rdata holds its old value.
- Counter reaches TIMEOUT without mem_valid:
  - Pulse the owner's done and err together; owner rdata = 0; go to IDLE.
  - A later stray mem_valid while in IDLE is ignored.
- mem_valid in IDLE is always ignored.
- Latency: a request sampled in IDLE gives mem_enable the next cycle. With a one-cycle RAM the done pulse arrives 2 cycles after the request was sampled. Throughput is one access per 3 cycles, because the done cycle returns the arbiter to IDLE before the next grant.
- Requester rule: on the cycle after done, the requester either deasserts req or presents a new request. A req still high in IDLE is treated as a new request.
- Request inputs are sampled only in IDLE. Changes during WAIT are ignored.
- The GPIO address 32'hFFFFFFFF passes through unchanged; the arbiter does no address decode.
- Reset mid-transaction: return to IDLE immediately; no done is issued for the aborted access.

Decomposition:
- Shared package mem_pkg:
  - typedef oplen_t (2-bit) with constants OPLEN_B = 00, OPLEN_H = 01, OPLEN_W = 11;
  - enum arb_state_t {IDLE, WAIT};
  - constant GPIO_ADDR = 32'hFFFFFFFF;
  - typedef owner_t {OWN_IF, OWN_D}.
- One natural sub-module: rr_pick2, a combinational two-way picker with inputs req_a, req_b, last, mode and output grant. It is unit-testable on its own.

Test Plan:
- Fetch after reset: if_req=1, if_addr=0, RAM freshly reset -> mem_enable pulses with mem_oplen=11, mem_we=0; if_done pulses 2 cycles after the request; if_rdata=32'h00100093; err=0.
- Store then load: d_req, d_addr=0x40, d_oplen=00, d_we=1, d_wdata=0xAB, then a load of the same address -> second d_done has d_rdata=32'h000000AB.
- GPIO write: d_addr=32'hFFFFFFFF, d_we=1, d_wdata=0x00001234, then a load -> d_rdata=32'h00001234; mem_addr=32'hFFFFFFFF on both commands.
- Contention, PRIO_MODE=0: if_req and d_req held high continuously, re-requesting after each done -> grants alternate D, IF, D, IF; no requester is starved over 8 grants. Same stimulus with PRIO_MODE=1 -> only D is served.
- Timeout: RAM model holds mem_valid=0, TIMEOUT=15 -> d_done and err pulse together 15 cycles after mem_enable; d_rdata=0; a stray mem_valid 2 cycles later causes no done.
- Reset in WAIT: assert rst between mem_enable and mem_valid -> outputs 0 immediately, no done pulse; the next fetch completes normally.
